// File: rtl/uart_pkg.sv
// Shared UART constants and helpers used by the RX path blocks.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned ERR_BIT         = UART_DATA_WIDTH;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Register-array storage for the RX FIFO: one synchronous write port, one async read port.
module uart_rx_fifo_mem #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic                                 clock,
  input  logic                                 we,
  input  logic [uart_pkg::clog2(DEPTH)-1:0]    waddr,
  input  logic [WIDTH-1:0]                     wdata,
  input  logic [uart_pkg::clog2(DEPTH)-1:0]    raddr,
  output logic [WIDTH-1:0]                     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is intentionally not reset; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive elastic buffer between uart_rx and the async handshake; marks the entry after a drop.
module uart_rx_fifo #(
  parameter int unsigned UART_DATA_WIDTH = uart_pkg::UART_DATA_WIDTH,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                din_valid,
  output logic                                din_ready,
  input  logic [UART_DATA_WIDTH:0]            din,
  output logic                                dout_valid,
  input  logic                                dout_ready,
  output logic [UART_DATA_WIDTH:0]            dout,
  output logic [uart_pkg::clog2(DEPTH):0]     level,
  output logic                                overrun
);

  import uart_pkg::clog2;

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned W  = UART_DATA_WIDTH;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, level_q;
  logic          overrun_q, ovr_pending_q;
  logic          empty, full, push, pop, drop, we;
  logic [W:0]    wdata, rdata;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = dout_valid & dout_ready;
  assign push  = din_valid & (~full | pop);
  assign drop  = din_valid & full & ~pop;
  assign we    = push & ~flush;
  // The first character after a drop carries the error bit so the gap is visible downstream.
  assign wdata = {din[W] | ovr_pending_q, din[W-1:0]};

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q          <= '0;
      rd_q          <= '0;
      level_q       <= '0;
      overrun_q     <= 1'b0;
      ovr_pending_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= wr_d - rd_d;
      if (flush) begin
        overrun_q     <= 1'b0;
        ovr_pending_q <= 1'b0;
      end else if (drop) begin
        overrun_q     <= 1'b1;
        ovr_pending_q <= 1'b1;
      end else if (push) begin
        ovr_pending_q <= 1'b0;
      end
    end
  end

  uart_rx_fifo_mem #(
    .WIDTH (W + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (we),
    .waddr (wr_q[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_q[AW-1:0]),
    .rdata (rdata)
  );

  assign din_ready  = ~reset;
  assign dout_valid = ~empty;
  // Mask the unreset storage so dout reads zero whenever nothing is queued.
  assign dout       = dout_valid ? rdata : '0;
  assign level      = level_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized checks of uart_rx_fifo (W=8, DEPTH=8).
module tb_uart_rx_fifo;

  logic       clock = 1'b0;
  logic       reset, flush, din_valid, dout_ready;
  logic       din_ready, dout_valid, overrun;
  logic [8:0] din, dout;
  logic [3:0] level;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  uart_rx_fifo #(
    .UART_DATA_WIDTH (8),
    .DEPTH           (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din        (din),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .level      (level),
    .overrun    (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [8:0] d);
    din_valid = 1'b1;
    din       = d;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [8:0] exp);
    check({tag, "_valid"}, 32'(dout_valid), 32'd1);
    check({tag, "_data"}, 32'(dout), 32'(exp));
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  task automatic fill_1_to_8();
    for (int i = 1; i <= 8; i++) push_one(9'(i));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  logic [8:0] q[$];
  logic       m_pend, m_ovr, m_pop, m_push, m_drop, dv, rdy;
  logic [8:0] d;

  initial begin
    reset = 1'b1; flush = 1'b0; din_valid = 1'b0; dout_ready = 1'b0; din = '0;
    tick(); tick();
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    reset = 1'b0;
    tick();
    check("din_ready_up", 32'(din_ready), 32'd1);

    // 1: single push, held stable with no ready
    check("t1_pre_valid", 32'(dout_valid), 32'd0);
    push_one(9'h0A5);
    check("t1_valid", 32'(dout_valid), 32'd1);
    check("t1_level", 32'(level), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("t1_stable", 32'(dout), 32'h0A5);
      tick();
    end
    pop_expect("t1_pop", 9'h0A5);
    check("t1_empty", 32'(dout_valid), 32'd0);
    check("t1_level0", 32'(level), 32'd0);

    // 2: fill to DEPTH, then drain in order
    fill_1_to_8();
    check("t2_level", 32'(level), 32'd8);
    check("t2_din_ready", 32'(din_ready), 32'd1);
    check("t2_overrun", 32'(overrun), 32'd0);
    dout_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("t2_drain", 32'(dout), 32'(i));
      tick();
    end
    dout_ready = 1'b0;
    check("t2_empty", 32'(dout_valid), 32'd0);

    // 3: overrun drops 0xFF and marks the next stored character
    fill_1_to_8();
    push_one(9'h0FF);
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_level", 32'(level), 32'd8);
    pop_expect("t3_first", 9'h001);
    push_one(9'h033);
    for (int i = 2; i <= 8; i++) pop_expect("t3_drain", 9'(i));
    pop_expect("t3_marked", 9'h133);
    check("t3_empty", 32'(dout_valid), 32'd0);
    push_one(9'h022);
    pop_expect("t3_unmarked", 9'h022);
    check("t3_sticky", 32'(overrun), 32'd1);

    // 4: simultaneous push and pop while full
    do_flush();
    check("t4_flush_ovr", 32'(overrun), 32'd0);
    fill_1_to_8();
    din_valid = 1'b1; din = 9'h044; dout_ready = 1'b1;
    tick();
    din_valid = 1'b0; dout_ready = 1'b0;
    check("t4_level", 32'(level), 32'd8);
    check("t4_overrun", 32'(overrun), 32'd0);
    for (int i = 2; i <= 8; i++) pop_expect("t4_drain", 9'(i));
    pop_expect("t4_last", 9'h044);

    // 5: flush beats a same-cycle push
    fill_1_to_8();
    push_one(9'h0FF);
    for (int i = 1; i <= 3; i++) pop_expect("t5_pop", 9'(i));
    check("t5_level5", 32'(level), 32'd5);
    check("t5_ovr1", 32'(overrun), 32'd1);
    flush = 1'b1; din_valid = 1'b1; din = 9'h055;
    tick();
    flush = 1'b0; din_valid = 1'b0;
    check("t5_level0", 32'(level), 32'd0);
    check("t5_valid0", 32'(dout_valid), 32'd0);
    check("t5_ovr0", 32'(overrun), 32'd0);
    tick();
    check("t5_not_stored", 32'(level), 32'd0);
    push_one(9'h011);
    pop_expect("t5_no_mark", 9'h011);

    // 6: async reset mid-stream, then randomized scoreboard run
    push_one(9'h061); push_one(9'h062); push_one(9'h063);
    dout_ready = 1'b1; tick(); dout_ready = 1'b0; tick();
    check("t6_level2", 32'(level), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("t6_arst_valid", 32'(dout_valid), 32'd0);
    check("t6_arst_level", 32'(level), 32'd0);
    check("t6_arst_ovr", 32'(overrun), 32'd0);
    check("t6_arst_ready", 32'(din_ready), 32'd0);
    check("t6_arst_dout", 32'(dout), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    m_pend = 1'b0; m_ovr = 1'b0;
    for (int c = 0; c < 300; c++) begin
      dv  = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 5);
      d   = 9'($urandom_range(0, 511));
      din_valid = dv; din = d; dout_ready = rdy;
      check("rnd_valid", 32'(dout_valid), 32'(q.size() != 0));
      check("rnd_level", 32'(level), 32'(q.size()));
      if (q.size() != 0) check("rnd_dout", 32'(dout), 32'(q[0]));
      m_pop  = rdy && (q.size() != 0);
      m_push = dv && ((q.size() != 8) || m_pop);
      m_drop = dv && (q.size() == 8) && !m_pop;
      tick();
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        q.push_back({d[uart_pkg::ERR_BIT] | m_pend, d[7:0]});
        m_pend = 1'b0;
      end
      if (m_drop) begin
        m_pend = 1'b1;
        m_ovr  = 1'b1;
      end
      check("rnd_overrun", 32'(overrun), 32'(m_ovr));
    end
    din_valid = 1'b0; dout_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
